merged_word_splitter: RTL and testbench

//  Decompression-side inverse of the two-word merge stage. Accepts one merged

---
 rtl/merged_word_splitter_pkg.sv | 13 +
 rtl/merged_word_splitter_unshifter.sv | 19 +
 rtl/merged_word_splitter.sv | 138 +++++++++++++
 tb/tb_merged_word_splitter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merged_word_splitter_pkg.sv
// rtl/merged_word_splitter_pkg.sv - beat-state encoding and merge geometry shared by merge and split sides
package merged_word_splitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } beat_state_t;

    // A merged word always packs exactly two fields.
    localparam int MERGE_FACTOR = 2;

endpackage

// File: rtl/merged_word_splitter_unshifter.sv
// rtl/merged_word_splitter_unshifter.sv - right-aligns the second field; mirror of the merge-side shifter
module merged_word_splitter_unshifter
    import merged_word_splitter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [LEN_WIDTH-1:0]  i_shamt,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic w_overshift;

    // A first field filling the whole lane pushed the second field out entirely.
    assign w_overshift = (int'(i_shamt) >= DATA_WIDTH);
    assign o_data      = w_overshift ? '0 : (i_data >> i_shamt);

endmodule

// File: rtl/merged_word_splitter.sv
// rtl/merged_word_splitter.sv - replays one merged double-width word as up to two single-width beats
module merged_word_splitter
    import merged_word_splitter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MERGE_FACTOR*DATA_WIDTH-1:0] in_data,
    input  logic [MERGE_FACTOR*TAG_WIDTH-1:0]  in_tag,
    input  logic [LEN_WIDTH-1:0]               in_len,
    input  logic [LEN_WIDTH-1:0]               in_len0,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [TAG_WIDTH-1:0]               out_tag,
    output logic [LEN_WIDTH-1:0]               out_len,
    output logic                               out_last,
    output logic                               len_err
);

    beat_state_t r_state;
    beat_state_t w_next_state;

    logic                  w_accept;
    logic                  w_retire;
    logic                  w_len_err;
    logic                  w_single;
    logic [LEN_WIDTH-1:0]  w_len1;
    logic [DATA_WIDTH-1:0] w_unshifted;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic [LEN_WIDTH-1:0]  r_out_len;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [TAG_WIDTH-1:0]  r_hold_tag;
    logic [LEN_WIDTH-1:0]  r_hold_len;
    logic                  r_len_err;

    // Ready in IDLE, or while the final beat of the current word is retiring.
    assign in_ready  = reset && ((r_state == ST_IDLE) || (r_out_last && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = r_out_valid && out_ready;

    // An inconsistent length pair collapses to a single beat, so the subtraction never wraps.
    assign w_len_err = (in_len0 > in_len);
    assign w_len1    = w_len_err ? '0 : (in_len - in_len0);
    assign w_single  = (w_len1 == '0);

    merged_word_splitter_unshifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_unshifter (
        .i_data  (in_data[DATA_WIDTH-1:0]),
        .i_shamt (in_len0),
        .o_data  (w_unshifted)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_BEAT0;
            end
            ST_BEAT0: begin
                if (w_retire) begin
                    if (!r_out_last)   w_next_state = ST_BEAT1;
                    else if (w_accept) w_next_state = ST_BEAT0;
                    else               w_next_state = ST_IDLE;
                end
            end
            ST_BEAT1: begin
                if (w_retire) w_next_state = w_accept ? ST_BEAT0 : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Beat0 goes straight to the output registers; beat1 waits in the holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_len   <= '0;
            r_out_last  <= 1'b0;
            r_hold_data <= '0;
            r_hold_tag  <= '0;
            r_hold_len  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[MERGE_FACTOR*DATA_WIDTH-1:DATA_WIDTH];
            r_out_tag   <= in_tag[MERGE_FACTOR*TAG_WIDTH-1:TAG_WIDTH];
            r_out_len   <= in_len0;
            r_out_last  <= w_single;
            r_hold_data <= w_unshifted;
            r_hold_tag  <= in_tag[TAG_WIDTH-1:0];
            r_hold_len  <= w_len1;
        end else if (w_retire && (r_state == ST_BEAT0) && !r_out_last) begin
            r_out_data  <= r_hold_data;
            r_out_tag   <= r_hold_tag;
            r_out_len   <= r_hold_len;
            r_out_last  <= 1'b1;
        end else if (w_retire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_err <= 1'b0;
        end else if (w_accept && w_len_err) begin
            r_len_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_len   = r_out_len;
    assign out_last  = r_out_last;
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_merged_word_splitter.sv
// tb/tb_merged_word_splitter.sv - scoreboard bench for merged_word_splitter
module tb_merged_word_splitter;

    localparam int DW = 32;
    localparam int TW = 2;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*DW-1:0] in_data = '0;
    logic [2*TW-1:0] in_tag = '0;
    logic [LW-1:0] in_len = '0;
    logic [LW-1:0] in_len0 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic [LW-1:0] out_len;
    logic          out_last;
    logic          len_err;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic [LW-1:0] len;
        logic          last;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    bit   rdy_q[$];
    int   retire_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;
    int   hold_checks = 0;
    bit   mon_en = 1'b0;
    bit   model_err = 1'b0;
    bit   prev_hold = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    merged_word_splitter #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_len    (in_len),
        .in_len0   (in_len0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_len   (out_len),
        .out_last  (out_last),
        .len_err   (len_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: split by length arithmetic, second field recovered by undoing the merge shift.
    task automatic push_model(input logic [63:0] d, input logic [3:0] t,
                              input logic [7:0] l, input logic [7:0] l0);
        exp_t        e;
        logic        bad;
        logic [7:0]  l1;
        logic [63:0] lo;
        bad = (l0 > l);
        l1  = bad ? 8'd0 : 8'(l - l0);
        if (bad) model_err = 1'b1;
        e.data = d[63:32];
        e.tag  = t[3:2];
        e.len  = l0;
        e.last = (l1 == 8'd0);
        e.err  = model_err;
        sb_q.push_back(e);
        if (l1 != 8'd0) begin
            lo     = {32'd0, d[31:0]};
            e.data = (l0 >= 8'd32) ? 32'd0 : 32'(lo >> l0);
            e.tag  = t[1:0];
            e.len  = l1;
            e.last = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rdy_q.size() > 0)   out_ready = rdy_q.pop_front();
        else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else                    out_ready = (ready_mode == 1);
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_en && reset) begin
            if (prev_hold) begin
                hold_checks++;
                chk("hold_valid", 64'(out_valid), 64'd1);
                if (sb_q.size() > 0) begin
                    chk("hold_data", 64'(out_data), 64'(sb_q[0].data));
                    chk("hold_len", 64'(out_len), 64'(sb_q[0].len));
                end
            end
            if (out_valid && out_ready) begin
                retire_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_tag", 64'(out_tag), 64'(e.tag));
                    chk("beat_len", 64'(out_len), 64'(e.len));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                    chk("beat_len_err", 64'(len_err), 64'(e.err));
                end
            end
            prev_hold = out_valid && !out_ready;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Called on a falling edge; returns on the falling edge after the word is taken.
    task automatic send_word(input logic [63:0] d, input logic [3:0] t,
                             input logic [7:0] l, input logic [7:0] l0);
        int budget = 200;
        bit done   = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        in_len   = l;
        in_len0  = l0;
        while (!done && budget > 0) begin
            #2;
            if (in_ready) begin
                push_model(d, t, l, l0);
                done = 1'b1;
            end
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        int budget = 400;
        while ((sb_q.size() > 0 || out_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] f0, f1;
        logic [7:0]  l0, l1, lt;
        logic [63:0] shifted;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        send_word({32'hAAAA0001, 32'h00000050}, 4'b1001, 8'd7, 8'd4);
        drain();

        send_word({32'hAAAA0001, 32'h00000050}, 4'b1001, 8'd4, 8'd4);
        drain();
        #2;
        chk("t2_in_ready", 64'(in_ready), 64'd1);
        chk("t2_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);

        retire_cyc.delete();
        send_word({32'h11111111, 32'h00001230}, 4'b0110, 8'd20, 8'd4);
        send_word({32'h22222222, 32'h0000ABC0}, 4'b1100, 8'd24, 8'd8);
        send_word({32'h33333333, 32'h00000000}, 4'b0011, 8'd40, 8'd33);
        drain();
        chk("t3_beats", 64'(retire_cyc.size()), 64'd6);
        if (retire_cyc.size() == 6)
            chk("t3_span", 64'(retire_cyc[5] - retire_cyc[0]), 64'd5);

        hold_checks = 0;
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        send_word({32'hAAAA0001, 32'h00000050}, 4'b1001, 8'd7, 8'd4);
        drain();
        chk("t4_hold_cycles", 64'(hold_checks), 64'd2);

        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            f0 = $urandom;
            f1 = $urandom;
            l0 = 8'($urandom_range(0, 40));
            l1 = 8'($urandom_range(0, 32));
            lt = 8'(l0 + l1);
            if ($urandom_range(0, 9) == 0 && l0 > 8'd0) lt = 8'($urandom_range(0, int'(l0) - 1));
            shifted = 64'(f1) << l0;
            send_word({f0, shifted[31:0]}, 4'($urandom), lt, l0);
        end
        drain();
        ready_mode = 1;

        send_word({32'hDEAD0005, 32'h12345678}, 4'b1110, 8'd5, 8'd9);
        drain();
        chk("t5_len_err", 64'(len_err), 64'd1);
        send_word({32'h0000BEEF, 32'h00000300}, 4'b0100, 8'd12, 8'd8);
        drain();
        chk("t5_sticky", 64'(len_err), 64'd1);

        ready_mode = 0;
        send_word({32'hCAFE0001, 32'h00000070}, 4'b1001, 8'd8, 8'd4);
        #2;
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_len_err", 64'(len_err), 64'd0);
        sb_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        ready_mode = 1;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("t6_no_replay", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        mon_en = 1'b1;
        send_word({32'hAAAA0001, 32'h00000050}, 4'b1001, 8'd7, 8'd4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
